// File: rtl/float_mult_pipe.sv
// float_mult_pipe: three-stage binary floating-point multiplier {sign, exp, frac}.
// Stage 1 unpacks, classifies and normalises subnormal operands. Stage 2 multiplies
// the significands and sums the exponents. Stage 3 normalises or denormalises,
// rounds, packs and raises flags. One shared advance enable moves every stage, so a
// stalled consumer freezes the whole pipe and nothing is dropped or duplicated.

module float_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int FRAC_W = 10,
  localparam int FLOAT_W = 1 + EXP_W + FRAC_W
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] float1,
  input  logic [FLOAT_W-1:0] float2,
  input  logic               rnd_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] product,
  output logic [3:0]         flags
);

  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int MW     = SIG_W + 1;
  localparam int EW     = EXP_W + 3;
  localparam int EMAX   = 2**EXP_W - 1;
  localparam int MAX_SH = FRAC_W + 2;

  // Unpacked operand: class bits plus a normalised significand and its exponent.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             inf;
    logic             nan;
    logic             snan;
    logic [EW-1:0]    exp;
    logic [SIG_W-1:0] sig;
  } op_t;

  // Number of zeros above the highest set bit (SIG_W when the value is zero).
  function automatic int lead_zeros(input logic [SIG_W-1:0] v);
    int n;
    n = SIG_W;
    for (int i = 0; i < SIG_W; i++) begin
      if (v[i]) n = SIG_W - 1 - i;
    end
    return n;
  endfunction

  // Subnormals are shifted up until the hidden bit is set; their exponent goes
  // below 1 by the same amount so the value is unchanged.
  function automatic op_t unpack(input logic [FLOAT_W-1:0] f);
    op_t o;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] m;
    logic [SIG_W-1:0] s;
    int lz;
    e = f[FLOAT_W-2 -: EXP_W];
    m = f[FRAC_W-1:0];
    s = {(e != '0), m};
    o.sign = f[FLOAT_W-1];
    o.zero = (e == '0) && (m == '0);
    o.inf  = (e == '1) && (m == '0);
    o.nan  = (e == '1) && (m != '0);
    o.snan = o.nan && !m[FRAC_W-1];
    if (e == '0) begin
      lz = lead_zeros(s);
      o.sig = s << lz;
      o.exp = EW'(1 - lz);
    end else begin
      lz = 0;
      o.sig = s;
      o.exp = EW'(e);
    end
    return o;
  endfunction

  logic advance;
  logic v1, v2;

  op_t op1, op2;

  logic             s1_sign, s1_nan, s1_nv, s1_inf, s1_zero, s1_rnd;
  logic [EW-1:0]    s1_exp1, s1_exp2;
  logic [SIG_W-1:0] s1_sig1, s1_sig2;

  logic [PROD_W-1:0] prod_s2;
  logic [EW-1:0]     exp_s2;

  logic              s2_sign, s2_nan, s2_nv, s2_inf, s2_zero, s2_rnd;
  logic [EW-1:0]     s2_exp;
  logic [PROD_W-1:0] s2_prod;

  logic [PROD_W-1:0]  norm, den;
  logic [SIG_W-1:0]   kept, mant_n;
  logic [MW-1:0]      mant_r;
  logic               tiny, lost, guard, sticky, inexact, round_up;
  int                 e_n, e_r, sh;
  logic [FLOAT_W-1:0] res;
  logic [3:0]         res_flags;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign op1 = unpack(float1);
  assign op2 = unpack(float2);

  // Stage valid bits and out_valid move together whenever the pipe advances.
  always_ff @(posedge CLK) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Stage 1 register: sign, normalised operands and the special-case outcome.
  always_ff @(posedge CLK) begin
    if (advance) begin
      s1_sign <= op1.sign ^ op2.sign;
      s1_exp1 <= op1.exp;
      s1_exp2 <= op2.exp;
      s1_sig1 <= op1.sig;
      s1_sig2 <= op2.sig;
      s1_nan  <= op1.nan || op2.nan || (op1.zero && op2.inf) || (op1.inf && op2.zero);
      s1_nv   <= op1.snan || op2.snan || (op1.zero && op2.inf) || (op1.inf && op2.zero);
      s1_inf  <= op1.inf || op2.inf;
      s1_zero <= op1.zero || op2.zero;
      s1_rnd  <= rnd_mode;
    end
  end

  // Full-width significand product lies in [1,4) scaled by 2^(2*FRAC_W); the
  // exponent sum is signed and wide enough to hold any under- or overflow.
  assign prod_s2 = PROD_W'(s1_sig1) * PROD_W'(s1_sig2);
  assign exp_s2  = $signed(s1_exp1) + $signed(s1_exp2) - EW'(BIAS);

  // Stage 2 register: raw product, exponent and the carried-through class bits.
  always_ff @(posedge CLK) begin
    if (advance) begin
      s2_prod <= prod_s2;
      s2_exp  <= exp_s2;
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_nv   <= s1_nv;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
      s2_rnd  <= s1_rnd;
    end
  end

  // Stage 3 logic: align to a leading one, denormalise tiny results, round, pack.
  always_comb begin
    norm = s2_prod;
    e_n  = int'($signed(s2_exp));
    if (s2_prod[PROD_W-1]) begin
      e_n = e_n + 1;
    end else begin
      norm = s2_prod << 1;
    end

    tiny = (e_n < 1);
    sh   = 0;
    den  = norm;
    lost = 1'b0;
    if (tiny) begin
      sh = 1 - e_n;
      if (sh > MAX_SH) begin
        den  = '0;
        lost = 1'b1;
      end else begin
        den  = norm >> sh;
        lost = |(norm & ~({PROD_W{1'b1}} << sh));
      end
    end

    kept     = den[PROD_W-1 -: SIG_W];
    guard    = den[SIG_W-1];
    sticky   = (|den[SIG_W-2:0]) || lost;
    inexact  = guard || sticky;
    round_up = !s2_rnd && guard && (sticky || kept[0]);
    mant_r   = {1'b0, kept} + MW'(round_up);

    e_r = tiny ? 1 : e_n;
    if (mant_r[SIG_W]) begin
      mant_n = mant_r[SIG_W:1];
      e_r    = e_r + 1;
    end else begin
      mant_n = mant_r[SIG_W-1:0];
    end

    res       = '0;
    res_flags = '0;
    if (s2_nan) begin
      res       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      res_flags = {s2_nv, 3'b000};
    end else if (s2_inf) begin
      res = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (s2_zero) begin
      res = {s2_sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (e_r >= EMAX) begin
      if (s2_rnd) begin
        res = {s2_sign, EXP_W'(EMAX - 1), {FRAC_W{1'b1}}};
      end else begin
        res = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end
      res_flags = 4'b0101;
    end else begin
      res = {s2_sign, (mant_n[SIG_W-1] ? EXP_W'(e_r) : {EXP_W{1'b0}}), mant_n[FRAC_W-1:0]};
      res_flags = {1'b0, 1'b0, tiny && inexact, inexact};
    end
  end

  // Output register: loads a new result only when a valid one moves in, and
  // holds while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (rst) begin
      product <= '0;
      flags   <= '0;
    end else if (advance && v2) begin
      product <= res;
      flags   <= res_flags;
    end
  end

endmodule

// File: tb/tb_float_mult_pipe.sv
// tb_float_mult_pipe: directed vectors for the half-precision configuration of
// float_mult_pipe, one task per feature, expected values worked out by hand.

module tb_float_mult_pipe;

  logic        CLK = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] float1;
  logic [15:0] float2;
  logic        rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  float_mult_pipe #(.EXP_W(5), .FRAC_W(10)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float1    (float1),
    .float2    (float2),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .flags     (flags)
  );

  always #5 CLK = ~CLK;

  // Issue one operation into an idle pipe and wait (bounded) for its result.
  // lat counts clock edges from the transfer edge; -1 means no result appeared.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic rm,
                        output logic [15:0] res, output logic [3:0] flg, output int lat);
    int edges;
    float1    = a;
    float2    = b;
    rnd_mode  = rm;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 12) begin
      @(posedge CLK); #1;
      edges++;
    end
    lat = out_valid ? edges : -1;
    res = product;
    flg = flags;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    float1    = '0;
    float2    = '0;
    rnd_mode  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (product !== 16'h0000 || flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h flags=%b want=0000 flags=0000", product, flags);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_latency;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    run_op(16'h3C00, 16'h3C00, 1'b0, res, flg, lat);
    checks++;
    if (res !== 16'h3C00 || flg !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL one_x_one got=%h flags=%b want=3c00 flags=0000", res, flg);
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("[TB] FAIL latency got=%0d want=3", lat);
    end
  endtask

  task automatic test_arith;
    logic [15:0] av [7] = '{16'hBC00, 16'h8000, 16'hFC00, 16'h7C00, 16'h3DA8, 16'h3DA8, 16'h3BFF};
    logic [15:0] bv [7] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h8001, 16'h3DA8, 16'h3DA8, 16'h3BFF};
    logic        rv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] pv [7] = '{16'hBC00, 16'h8000, 16'hFC00, 16'hFC00, 16'h4000, 16'h3FFF, 16'h3BFE};
    logic [3:0]  fv [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(av[i], bv[i], rv[i], res, flg, lat);
      checks++;
      if (res !== pv[i] || flg !== fv[i] || lat != 3) begin
        failures++;
        $display("[TB] FAIL arith[%0d] got=%h flags=%b lat=%0d want=%h flags=%b lat=3",
                 i, res, flg, lat, pv[i], fv[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic        rv [2] = '{1'b0, 1'b1};
    logic [15:0] pv [2] = '{16'h7C00, 16'h7BFF};
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_op(16'h7BFF, 16'h4000, rv[i], res, flg, lat);
      checks++;
      if (res !== pv[i] || flg !== 4'b0101) begin
        failures++;
        $display("[TB] FAIL overflow[%0d] got=%h flags=%b want=%h flags=0101", i, res, flg, pv[i]);
      end
    end
  endtask

  task automatic test_nan;
    logic [15:0] av [4] = '{16'h0000, 16'h7D00, 16'h7E00, 16'hFE00};
    logic [15:0] bv [4] = '{16'hFC00, 16'h3C00, 16'h3C00, 16'h3C00};
    logic [3:0]  fv [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], 1'b0, res, flg, lat);
      checks++;
      if (res !== 16'h7E00 || flg !== fv[i]) begin
        failures++;
        $display("[TB] FAIL nan[%0d] got=%h flags=%b want=7e00 flags=%b", i, res, flg, fv[i]);
      end
    end
  endtask

  task automatic test_subnormal;
    logic [15:0] av [6] = '{16'h0003, 16'h0001, 16'h0002, 16'h0200, 16'h0001, 16'h0001};
    logic [15:0] bv [6] = '{16'h3800, 16'h3800, 16'h3800, 16'h4400, 16'h0001, 16'h0001};
    logic        rv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] pv [6] = '{16'h0002, 16'h0000, 16'h0001, 16'h0800, 16'h0000, 16'h0000};
    logic [3:0]  fv [6] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0011};
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], bv[i], rv[i], res, flg, lat);
      checks++;
      if (res !== pv[i] || flg !== fv[i]) begin
        failures++;
        $display("[TB] FAIL subnormal[%0d] got=%h flags=%b want=%h flags=%b", i, res, flg, pv[i], fv[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] av [5] = '{16'h3C00, 16'h4000, 16'h3E00, 16'hC000, 16'h4200};
    logic [15:0] bv [5] = '{16'h4000, 16'h4000, 16'h4000, 16'h3800, 16'h4200};
    logic [15:0] pv [5] = '{16'h4000, 16'h4400, 16'h4200, 16'hBC00, 16'h4880};
    int   sent;
    int   got;
    logic in_fire;
    logic out_fire;
    sent     = 0;
    got      = 0;
    rnd_mode = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 5);
      float1    = av[(sent < 5) ? sent : 4];
      float2    = bv[(sent < 5) ? sent : 4];
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (cyc == 5) begin
        checks++;
        if (sent != 3 || in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stall_accepts got=%0d in_ready=%b want=3 in_ready=0", sent, in_ready);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (product !== pv[0] || flags !== 4'b0000) begin
          failures++;
          $display("[TB] FAIL held_output cyc=%0d got=%h flags=%b want=%h flags=0000",
                   cyc, product, flags, pv[0]);
        end
      end
      if (out_fire) begin
        checks++;
        if (product !== pv[got] || flags !== 4'b0000) begin
          failures++;
          $display("[TB] FAIL order[%0d] got=%h flags=%b want=%h flags=0000",
                   got, product, flags, pv[got]);
        end
        got++;
      end
      if (in_fire) sent++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5) begin
      failures++;
      $display("[TB] FAIL drain_count got=%0d want=5", got);
    end
  endtask

  task automatic test_reset_midflight;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    logic        stale;
    out_ready = 1'b1;
    rnd_mode  = 1'b0;
    float1    = 16'h4000;
    float2    = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL inflight_before_reset got=%b want=1", out_valid);
    end
    rst = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b0 || product !== 16'h0000 || flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midflight_reset got=%b/%h/%b want=0/0000/0000", out_valid, product, flags);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_ready got=%b want=1", in_ready);
    end
    stale = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stale_result got=%b want=0", stale);
    end
    run_op(16'h3E00, 16'h4000, 1'b0, res, flg, lat);
    checks++;
    if (res !== 16'h4200 || flg !== 4'b0000 || lat != 3) begin
      failures++;
      $display("[TB] FAIL fresh_after_reset got=%h flags=%b lat=%0d want=4200 flags=0000 lat=3",
               res, flg, lat);
    end
  endtask

  // Bound on the whole run in case the pipe locks up.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_overflow();
    test_nan();
    test_subnormal();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_mult_pipe.md
FLOAT_MULT_PIPE -- requirements
Module: float_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, meaning exponent field width (legal range 4..11).
REQ-002 SHALL have parameter FRAC_W, default 10, meaning stored fraction width (legal range 3..52).
REQ-003 SHALL derive localparam FLOAT_W = 1+EXP_W+FRAC_W and BIAS = 2^(EXP_W-1)-1.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operand pair present.
REQ-007 SHALL have port in_ready, output, 1, block accepts the operand pair this cycle.
REQ-008 SHALL have port float1, input, FLOAT_W, multiplicand {sign, exp, frac}.
REQ-009 SHALL have port float2, input, FLOAT_W, multiplier.
REQ-010 SHALL have port rnd_mode, input, 1, rounding mode: 0 = nearest-even, 1 = toward zero; sampled with the operands.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-013 SHALL have port product, output, FLOAT_W, rounded result.
REQ-014 SHALL have port flags, output, 4, {NV invalid, OF overflow, UF underflow, NX inexact}, valid with out_valid.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/classify/normalise subnormal inputs (leading-zero count), S2 (FRAC_W+1)x(FRAC_W+1) significand multiply and exponent sum, S3 normalise/denormalise, round, pack, flags.
REQ-016 SHALL transfer on in_valid & in_ready and on out_valid & out_ready only.
REQ-017 SHALL compute advance = ~out_valid | out_ready; all stages shift together when advance=1; in_ready = advance.
REQ-018 SHALL give latency exactly 3 cycles from input transfer to out_valid when out_ready is held high; throughput 1 result/cycle.
REQ-019 SHALL hold product, flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL preserve issue order; no result dropped or duplicated under any backpressure pattern.
REQ-021 SHALL set the result sign to sign1 XOR sign2 for all non-NaN results, including zero and infinity.
REQ-022 SHALL return canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0) for any NaN input, 0 x inf, or inf x 0.
REQ-023 SHALL raise NV for sNaN input (exp all ones, frac MSB 0, frac nonzero) or 0 x inf; a qNaN input SHALL NOT raise NV.
REQ-024 SHALL return signed infinity, flags 0, for inf x finite-nonzero; SHALL return signed zero, flags 0, for zero x finite.
REQ-025 SHALL compute the unbounded exponent in signed width EXP_W+3, so that no intermediate wraps.
REQ-026 SHALL round with guard bit plus sticky (OR of all lower bits); RNE ties go to even LSB; RTZ truncates.
REQ-027 SHALL renormalise when rounding carries out of the significand, incrementing the exponent.
REQ-028 SHALL, on overflow after rounding, return signed infinity (RNE) or signed max-finite (RTZ), with OF and NX set.
REQ-029 SHALL right-shift the significand into subnormal range when the exponent < 1, shifts up to FRAC_W+2 bits, collapsing the rest into sticky; larger shifts give a pure-sticky value.
REQ-030 SHALL set UF when the rounded result is tiny (determined before rounding) and inexact; exact subnormals SHALL NOT raise UF.
REQ-031 SHALL set NX whenever any discarded bit was nonzero.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, clear out_valid and all stage valid bits, and set product=0 and flags=0.
REQ-033 SHALL discard in-flight operations on reset mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 SHALL NOT reset datapath registers other than product/flags; their contents are don't-care while valid=0.

Verification (FLOAT_W=16, rnd_mode=0 unless stated)
REQ-035 SHALL check 0x3C00 x 0x3C00 with out_ready=1 -> 0x3C00, flags 0, out_valid exactly 3 cycles after transfer.
REQ-036 SHALL check 0x7BFF x 0x4000 -> 0x7C00 with OF|NX; the same with rnd_mode=1 -> 0x7BFF with OF|NX.
REQ-037 SHALL check 0x0000 x 0xFC00 -> 0x7E00 with NV only; 0x7D00 x 0x3C00 -> 0x7E00 with NV; 0x7E00 x 0x3C00 -> 0x7E00 with flags 0.
REQ-038 SHALL check 0x0003 x 0x3800 -> 0x0002 with UF|NX; 0x0001 x 0x3800 -> 0x0000 with UF|NX (tie to even); 0x0002 x 0x3800 -> 0x0001 with flags 0.
REQ-039 SHALL check backpressure: issue 5 back-to-back ops with out_ready=0 for 6 cycles -> in_ready falls after 3 accepts, held outputs stay stable, and all results emerge in order once out_ready=1.
REQ-040 SHALL check that asserting rst with 3 ops in flight gives out_valid=0 next cycle, no stale result later, and a fresh op after reset with 3-cycle latency.
